// File: rtl/rv32i_dbg_port.sv
// Host debug/loader port for rv32i_seq: halts the core and performs byte-serial memory, regfile and PC accesses.
// Optional feature macro: RV32I_DBG_PC_WRITE_EN (adds pc_we/pc_wdata and allows PC writes).
module rv32i_dbg_port #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DMEM_BYTES = 4096,
  parameter int unsigned IMEM_BYTES = 4096
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [1:0]      cmd_target,
  input  logic [XLEN-1:0] cmd_addr,
  input  logic [2:0]      cmd_nbytes,
  input  logic [XLEN-1:0] cmd_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            halt_req,
  input  logic            halted,
  output logic            mem_sel,
  output logic            mem_en,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [7:0]      mem_wdata,
  input  logic [7:0]      mem_rdata,
  output logic [4:0]      rf_addr,
  output logic            rf_we,
  output logic [XLEN-1:0] rf_wdata,
  input  logic [XLEN-1:0] rf_rdata,
  input  logic [XLEN-1:0] pc_value
`ifdef RV32I_DBG_PC_WRITE_EN
  ,
  output logic            pc_we,
  output logic [XLEN-1:0] pc_wdata
`endif
);

  localparam int unsigned AW = XLEN + 1;
  localparam logic [1:0] T_DMEM = 2'd0;
  localparam logic [1:0] T_IMEM = 2'd1;
  localparam logic [1:0] T_REGF = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_HALT_WAIT, S_ACCESS, S_CAPTURE, S_RESP} state_e;

  state_e            state_q, state_d;
  logic              c_write_q, c_write_d;
  logic [1:0]        c_target_q, c_target_d;
  logic [XLEN-1:0]   c_addr_q, c_addr_d;
  logic [2:0]        c_nbytes_q, c_nbytes_d;
  logic [XLEN-1:0]   c_wdata_q, c_wdata_d;
  logic [1:0]        idx_q, idx_d;
  logic [XLEN-1:0]   acc_q, acc_d;

  logic              cmd_ready_d, rsp_valid_d, rsp_err_d, halt_req_d;
  logic [XLEN-1:0]   rsp_rdata_d;
  logic              mem_sel_d, mem_en_d, mem_we_d;
  logic [XLEN-1:0]   mem_addr_d;
  logic [7:0]        mem_wdata_d;
  logic [4:0]        rf_addr_d;
  logic              rf_we_d;
  logic [XLEN-1:0]   rf_wdata_d;
`ifdef RV32I_DBG_PC_WRITE_EN
  logic              pc_we_d;
  logic [XLEN-1:0]   pc_wdata_d;
`endif

  logic [AW-1:0]     end_addr_c, limit_c;
  logic              err_c, issue_c, last_c;
  logic [XLEN-1:0]   acc_new_c;

  // Command rejection decode; the range check is one bit wider than XLEN so it cannot wrap.
  always_comb begin
    end_addr_c = AW'(cmd_addr) + AW'(cmd_nbytes);
    limit_c    = (cmd_target == T_IMEM) ? AW'(IMEM_BYTES) : AW'(DMEM_BYTES);
    err_c      = 1'b0;
    unique case (cmd_target)
      T_DMEM, T_IMEM: err_c = (cmd_nbytes == 3'd0) || (cmd_nbytes > 3'd4) || (end_addr_c > limit_c);
      T_REGF:         err_c = (cmd_addr > XLEN'(31));
`ifdef RV32I_DBG_PC_WRITE_EN
      default:        err_c = cmd_write && (cmd_wdata[1:0] != 2'b00);
`else
      default:        err_c = cmd_write;
`endif
    endcase
  end

  always_comb begin
    state_d     = state_q;
    c_write_d   = c_write_q;
    c_target_d  = c_target_q;
    c_addr_d    = c_addr_q;
    c_nbytes_d  = c_nbytes_q;
    c_wdata_d   = c_wdata_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    cmd_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    halt_req_d  = 1'b0;
    mem_sel_d   = mem_sel;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    rf_addr_d   = rf_addr;
    rf_we_d     = 1'b0;
    rf_wdata_d  = rf_wdata;
`ifdef RV32I_DBG_PC_WRITE_EN
    pc_we_d     = 1'b0;
    pc_wdata_d  = pc_wdata;
`endif
    issue_c     = 1'b0;
    last_c      = (idx_q == 2'(c_nbytes_q - 3'd1));
    acc_new_c   = acc_q | (XLEN'(mem_rdata) << {idx_q, 3'b000});

    unique case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready) begin
          c_write_d   = cmd_write;
          c_target_d  = cmd_target;
          c_addr_d    = cmd_addr;
          c_nbytes_d  = cmd_nbytes;
          c_wdata_d   = cmd_wdata;
          rf_addr_d   = cmd_addr[4:0];
          rf_wdata_d  = cmd_wdata;
`ifdef RV32I_DBG_PC_WRITE_EN
          pc_wdata_d  = cmd_wdata;
`endif
          cmd_ready_d = 1'b0;
          idx_d       = 2'd0;
          acc_d       = '0;
          if (err_c) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d    = S_HALT_WAIT;
            halt_req_d = 1'b1;
          end
        end
      end
      S_HALT_WAIT: begin
        halt_req_d = 1'b1;
        if (halted) begin
          state_d = S_ACCESS;
          issue_c = 1'b1;
        end
      end
      S_ACCESS: begin
        halt_req_d = 1'b1;
        if (c_target_q == T_DMEM || c_target_q == T_IMEM) begin
          if (!c_write_q) begin
            state_d = S_CAPTURE;
          end else if (last_c) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
          end else begin
            idx_d   = idx_q + 2'd1;
            issue_c = 1'b1;
          end
        end else begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          if (!c_write_q) rsp_rdata_d = (c_target_q == T_REGF) ? rf_rdata : pc_value;
        end
      end
      S_CAPTURE: begin
        halt_req_d = 1'b1;
        if (last_c) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = acc_new_c;
        end else begin
          state_d = S_ACCESS;
          idx_d   = idx_q + 2'd1;
          acc_d   = acc_new_c;
          issue_c = 1'b1;
        end
      end
      S_RESP: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = rsp_err;
        rsp_rdata_d = rsp_rdata;
        halt_req_d  = halt_req;
        if (rsp_ready) begin
          state_d     = S_IDLE;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
          halt_req_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered, so the access for byte idx_d is set up one cycle ahead.
    if (issue_c) begin
      if (c_target_q == T_REGF) begin
        rf_we_d = c_write_q && (c_addr_q[4:0] != 5'd0);
      end else if (c_target_q == T_DMEM || c_target_q == T_IMEM) begin
        mem_en_d    = 1'b1;
        mem_we_d    = c_write_q;
        mem_sel_d   = (c_target_q == T_IMEM);
        mem_addr_d  = c_addr_q + XLEN'(idx_d);
        mem_wdata_d = c_wdata_q[{idx_d, 3'b000} +: 8];
      end else begin
`ifdef RV32I_DBG_PC_WRITE_EN
        pc_we_d = c_write_q;
`endif
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      c_write_q  <= 1'b0;
      c_target_q <= 2'd0;
      c_addr_q   <= '0;
      c_nbytes_q <= 3'd0;
      c_wdata_q  <= '0;
      idx_q      <= 2'd0;
      acc_q      <= '0;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
      halt_req   <= 1'b0;
      mem_sel    <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 8'd0;
      rf_addr    <= 5'd0;
      rf_we      <= 1'b0;
      rf_wdata   <= '0;
`ifdef RV32I_DBG_PC_WRITE_EN
      pc_we      <= 1'b0;
      pc_wdata   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      c_write_q  <= c_write_d;
      c_target_q <= c_target_d;
      c_addr_q   <= c_addr_d;
      c_nbytes_q <= c_nbytes_d;
      c_wdata_q  <= c_wdata_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      cmd_ready  <= cmd_ready_d;
      rsp_valid  <= rsp_valid_d;
      rsp_err    <= rsp_err_d;
      rsp_rdata  <= rsp_rdata_d;
      halt_req   <= halt_req_d;
      mem_sel    <= mem_sel_d;
      mem_en     <= mem_en_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      rf_addr    <= rf_addr_d;
      rf_we      <= rf_we_d;
      rf_wdata   <= rf_wdata_d;
`ifdef RV32I_DBG_PC_WRITE_EN
      pc_we      <= pc_we_d;
      pc_wdata   <= pc_wdata_d;
`endif
    end
  end

endmodule

// File: tb/tb_rv32i_dbg_port.sv
// Directed bench for rv32i_dbg_port with byte-memory and regfile models; honours RV32I_DBG_PC_WRITE_EN.
module tb_rv32i_dbg_port;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [1:0]  cmd_target = 2'd0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [2:0]  cmd_nbytes = 3'd0;
  logic        rsp_ready = 1'b0, halted = 1'b1;
  logic        cmd_ready, rsp_valid, rsp_err, halt_req;
  logic [31:0] rsp_rdata;
  logic        mem_sel, mem_en, mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'd0;
  logic [4:0]  rf_addr;
  logic        rf_we;
  logic [31:0] rf_wdata, rf_rdata;
  logic [31:0] pc_value = 32'h8000_0040;
`ifdef RV32I_DBG_PC_WRITE_EN
  logic        pc_we;
  logic [31:0] pc_wdata;
  int          pcwe_cnt = 0;
  logic [31:0] pc_last = '0;
`endif

  logic [7:0]  dmem [4096] = '{default: 8'h00};
  logic [7:0]  imem [4096] = '{default: 8'h00};
  logic [31:0] rf   [32];
  int          memen_cnt = 0, halt_cnt = 0, rfwe0_cnt = 0;
  int          checks = 0, errors = 0;

  always #5 clock = ~clock;

  rv32i_dbg_port dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_target(cmd_target), .cmd_addr(cmd_addr), .cmd_nbytes(cmd_nbytes), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .halt_req(halt_req), .halted(halted),
    .mem_sel(mem_sel), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rf_addr(rf_addr), .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
    .pc_value(pc_value)
`ifdef RV32I_DBG_PC_WRITE_EN
    , .pc_we(pc_we), .pc_wdata(pc_wdata)
`endif
  );

  assign rf_rdata = (rf_addr == 5'd0) ? 32'd0 : rf[rf_addr];

  // Core-side models plus strobe counters.
  always @(posedge clock) begin
    if (mem_en) begin
      memen_cnt <= memen_cnt + 1;
      if (mem_we) begin
        if (mem_sel) imem[mem_addr[11:0]] <= mem_wdata;
        else         dmem[mem_addr[11:0]] <= mem_wdata;
      end else begin
        mem_rdata <= mem_sel ? imem[mem_addr[11:0]] : dmem[mem_addr[11:0]];
      end
    end
    if (halt_req) halt_cnt <= halt_cnt + 1;
    if (rf_we && rf_addr == 5'd0) rfwe0_cnt <= rfwe0_cnt + 1;
    if (rf_we && rf_addr != 5'd0) rf[rf_addr] <= rf_wdata;
`ifdef RV32I_DBG_PC_WRITE_EN
    if (pc_we) begin
      pcwe_cnt <= pcwe_cnt + 1;
      pc_last  <= pc_wdata;
    end
`endif
  end

  task automatic do_cmd(input logic w, input logic [1:0] t, input logic [31:0] a,
                        input logic [2:0] n, input logic [31:0] wd,
                        output logic [31:0] rd, output logic e, output int lat);
    int cyc;
    @(negedge clock);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready); end
    cmd_valid = 1'b1; cmd_write = w; cmd_target = t; cmd_addr = a; cmd_nbytes = n; cmd_wdata = wd;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 100) begin @(posedge clock); #1; cyc++; end
    if (!rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: no rsp_valid after %0d cycles", cyc);
    end
    lat = cyc; rd = rsp_rdata; e = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b want 0", rsp_err); end
    checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL rst_rsp_rdata: got %h want 0", rsp_rdata); end
    checks++; if (halt_req !== 1'b0) begin errors++; $display("FAIL rst_halt_req: got %b want 0", halt_req); end
    checks++; if ({mem_en, mem_we, rf_we} !== 3'b000) begin errors++; $display("FAIL rst_strobes: got %b want 000", {mem_en, mem_we, rf_we}); end
  endtask

  task automatic test_dmem_write;
    logic [31:0] rd; logic e; int lat;
    do_cmd(1'b1, 2'd0, 32'h10, 3'd4, 32'hDEAD_BEEF, rd, e, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL wr4_latency: got %0d want 6", lat); end
    checks++; if (rd !== 32'd0 || e !== 1'b0) begin errors++; $display("FAIL wr4_rsp: got %h/%b want 0/0", rd, e); end
    checks++;
    if ({dmem[19], dmem[18], dmem[17], dmem[16]} !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr4_bytes: got %h want deadbeef", {dmem[19], dmem[18], dmem[17], dmem[16]});
    end
  endtask

  task automatic test_dmem_read;
    logic [31:0] rd; logic e; int lat;
    do_cmd(1'b0, 2'd0, 32'h10, 3'd2, 32'd0, rd, e, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL rd2_latency: got %0d want 6", lat); end
    checks++; if (rd !== 32'h0000_BEEF || e !== 1'b0) begin errors++; $display("FAIL rd2_data: got %h/%b want 0000beef/0", rd, e); end
    do_cmd(1'b0, 2'd0, 32'h11, 3'd3, 32'd0, rd, e, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL rd3_latency: got %0d want 8", lat); end
    checks++; if (rd !== 32'h00DE_ADBE) begin errors++; $display("FAIL rd3_data: got %h want 00deadbe", rd); end
    do_cmd(1'b0, 2'd0, 32'hFFF, 3'd1, 32'd0, rd, e, lat);
    checks++; if (lat !== 4 || e !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL rd1_top: got lat %0d err %b data %h want 4/0/0", lat, e, rd); end
  endtask

  task automatic test_regf;
    logic [31:0] rd; logic e; int lat; int x0_before;
    do_cmd(1'b1, 2'd2, 32'd5, 3'd0, 32'h1234, rd, e, lat);
    checks++; if (lat !== 3 || e !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL rf_wr: got lat %0d err %b data %h want 3/0/0", lat, e, rd); end
    do_cmd(1'b0, 2'd2, 32'd5, 3'd0, 32'd0, rd, e, lat);
    checks++; if (lat !== 3 || rd !== 32'h1234) begin errors++; $display("FAIL rf_rd: got lat %0d data %h want 3/00001234", lat, rd); end
    x0_before = rfwe0_cnt;
    do_cmd(1'b1, 2'd2, 32'd0, 3'd0, 32'hFFFF, rd, e, lat);
    checks++; if (rfwe0_cnt !== x0_before || e !== 1'b0) begin errors++; $display("FAIL rf_x0_wr: got %0d strobes err %b want 0/0", rfwe0_cnt - x0_before, e); end
    do_cmd(1'b0, 2'd2, 32'd32, 3'd0, 32'd0, rd, e, lat);
    checks++; if (lat !== 1 || e !== 1'b1) begin errors++; $display("FAIL rf_idx32: got lat %0d err %b want 1/1", lat, e); end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic e; int lat; int h0, m0;
    h0 = halt_cnt; m0 = memen_cnt;
    do_cmd(1'b0, 2'd1, 32'd4094, 3'd4, 32'd0, rd, e, lat);
    checks++; if (lat !== 1 || e !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL imem_oob: got lat %0d err %b data %h want 1/1/0", lat, e, rd); end
    checks++; if (halt_cnt !== h0 || memen_cnt !== m0) begin errors++; $display("FAIL err_quiet: got halt %0d mem_en %0d want 0/0", halt_cnt - h0, memen_cnt - m0); end
    do_cmd(1'b0, 2'd0, 32'd0, 3'd0, 32'd0, rd, e, lat);
    checks++; if (lat !== 1 || e !== 1'b1) begin errors++; $display("FAIL nbytes0: got lat %0d err %b want 1/1", lat, e); end
    do_cmd(1'b1, 2'd0, 32'd0, 3'd5, 32'd0, rd, e, lat);
    checks++; if (lat !== 1 || e !== 1'b1) begin errors++; $display("FAIL nbytes5: got lat %0d err %b want 1/1", lat, e); end
    do_cmd(1'b0, 2'd0, 32'hFFFF_FFFF, 3'd2, 32'd0, rd, e, lat);
    checks++; if (lat !== 1 || e !== 1'b1) begin errors++; $display("FAIL addr_wrap: got lat %0d err %b want 1/1", lat, e); end
    checks++; if (memen_cnt !== m0) begin errors++; $display("FAIL err_no_mem: got %0d strobes want 0", memen_cnt - m0); end
  endtask

  task automatic test_halt_wait;
    int cyc; int bad; logic [31:0] d0;
    bad = 0;
    halted = 1'b0;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_target = 2'd0; cmd_addr = 32'h10; cmd_nbytes = 3'd1;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    cyc = 1;
    checks++; if (halt_req !== 1'b1) begin errors++; $display("FAIL hw_halt_req: got %b want 1", halt_req); end
    repeat (10) begin
      if (mem_en) bad++;
      @(posedge clock); #1; cyc++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL hw_mem_early: got %0d strobes want 0", bad); end
    halted = 1'b1;
    while (!rsp_valid && cyc < 100) begin @(posedge clock); #1; cyc++; end
    checks++; if (cyc !== 14) begin errors++; $display("FAIL hw_latency: got %0d want 14", cyc); end
    checks++; if (rsp_rdata !== 32'h0000_00EF) begin errors++; $display("FAIL hw_data: got %h want 000000ef", rsp_rdata); end
    d0 = rsp_rdata; bad = 0;
    repeat (3) begin
      @(posedge clock); #1;
      if (!rsp_valid || rsp_rdata !== d0 || !halt_req) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL hw_rsp_hold: got %0d unstable cycles want 0", bad); end
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    checks++; if ({rsp_valid, halt_req, cmd_ready} !== 3'b001) begin errors++; $display("FAIL hw_release: got %b want 001", {rsp_valid, halt_req, cmd_ready}); end
  endtask

  task automatic test_pc;
    logic [31:0] rd; logic e; int lat;
    do_cmd(1'b0, 2'd3, 32'd0, 3'd0, 32'd0, rd, e, lat);
    checks++; if (lat !== 3 || rd !== 32'h8000_0040 || e !== 1'b0) begin errors++; $display("FAIL pc_rd: got lat %0d data %h err %b want 3/80000040/0", lat, rd, e); end
`ifdef RV32I_DBG_PC_WRITE_EN
    begin
      int p0;
      p0 = pcwe_cnt;
      do_cmd(1'b1, 2'd3, 32'd0, 3'd0, 32'h80, rd, e, lat);
      checks++; if (lat !== 3 || e !== 1'b0) begin errors++; $display("FAIL pc_wr: got lat %0d err %b want 3/0", lat, e); end
      checks++; if (pcwe_cnt !== p0 + 1 || pc_last !== 32'h80) begin errors++; $display("FAIL pc_we_pulse: got %0d pulses data %h want 1/00000080", pcwe_cnt - p0, pc_last); end
      do_cmd(1'b1, 2'd3, 32'd0, 3'd0, 32'h82, rd, e, lat);
      checks++; if (lat !== 1 || e !== 1'b1 || pcwe_cnt !== p0 + 1) begin errors++; $display("FAIL pc_wr_misalign: got lat %0d err %b want 1/1", lat, e); end
    end
`else
    do_cmd(1'b1, 2'd3, 32'd0, 3'd0, 32'h80, rd, e, lat);
    checks++; if (lat !== 1 || e !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL pc_wr_err: got lat %0d err %b data %h want 1/1/0", lat, e, rd); end
`endif
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic e; int lat;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_target = 2'd0; cmd_addr = 32'h100; cmd_nbytes = 3'd4; cmd_wdata = 32'hCAFE_F00D;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h101) begin errors++; $display("FAIL rm_byte2: got en %b addr %h want 1/00000101", mem_en, mem_addr); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, halt_req, mem_en, mem_we, rf_we} !== 7'b1000000 || rsp_rdata !== 32'd0) begin
      errors++; $display("FAIL rm_async: got %b want 1000000", {cmd_ready, rsp_valid, rsp_err, halt_req, mem_en, mem_we, rf_we});
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    checks++; if (dmem[256] !== 8'h0D || dmem[257] !== 8'h00) begin errors++; $display("FAIL rm_partial: got %h %h want 0d 00", dmem[256], dmem[257]); end
    do_cmd(1'b1, 2'd0, 32'h100, 3'd4, 32'h1122_3344, rd, e, lat);
    do_cmd(1'b0, 2'd0, 32'h100, 3'd4, 32'd0, rd, e, lat);
    checks++; if (lat !== 10 || rd !== 32'h1122_3344 || e !== 1'b0) begin errors++; $display("FAIL rm_after: got lat %0d data %h err %b want 10/11223344/0", lat, rd, e); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; logic e; int lat;
    do_cmd(1'b1, 2'd1, 32'd4092, 3'd4, 32'hA5B6_C7D8, rd, e, lat);
    checks++; if (lat !== 6 || e !== 1'b0) begin errors++; $display("FAIL b2b_imem_wr: got lat %0d err %b want 6/0", lat, e); end
    do_cmd(1'b0, 2'd1, 32'd4092, 3'd4, 32'd0, rd, e, lat);
    checks++; if (lat !== 10 || rd !== 32'hA5B6_C7D8) begin errors++; $display("FAIL b2b_imem_rd: got lat %0d data %h want 10/a5b6c7d8", lat, rd); end
    checks++; if (dmem[4092] !== 8'h00) begin errors++; $display("FAIL b2b_mem_sel: got dmem %h want 00", dmem[4092]); end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    test_reset;
    reset_n = 1'b1;
    test_dmem_write;
    test_dmem_read;
    test_regf;
    test_errors;
    test_halt_wait;
    test_pc;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
